// File: rtl/clock_divider_pkg.sv
// Project-wide clock constants shared by blocks that derive slow rates from the system clock.
package clock_divider_pkg;

  localparam int SYS_CLK_HZ = 100_000_000;

  // Converts a desired output frequency into the matching DIVIDER value.
  function automatic int divider_for_hz(input int target_hz);
    return SYS_CLK_HZ / target_hz;
  endfunction

endpackage

// File: rtl/clock_divider.sv
// Integer clock divider: a flop-driven slow square wave clk_out plus a one-cycle
// tick strobe in the clk domain that marks each clk_out rising edge.
module clock_divider
  import clock_divider_pkg::*;
#(
  parameter int DIVIDER = SYS_CLK_HZ
) (
  input  logic clk,
  input  logic reset,
  output logic clk_out,
  output logic tick
);

  localparam int CNT_W = (DIVIDER < 2) ? 1 : $clog2(DIVIDER);
  localparam logic [CNT_W-1:0] LAST   = CNT_W'(DIVIDER - 1);
  localparam logic [CNT_W-1:0] LO_CNT = CNT_W'(DIVIDER - DIVIDER / 2);

  if (DIVIDER < 2) begin : g_bad_divider
    $error("clock_divider: DIVIDER must be at least 2");
  end

  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_next;

  always_comb begin
    cnt_next = cnt + CNT_W'(1);
    if (cnt == LAST) begin
      cnt_next = '0;
    end
  end

  // Low phase spans counts 0..LO-1, high phase LO..DIVIDER-1, so odd dividers run low one cycle longer.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt     <= '0;
      clk_out <= 1'b0;
      tick    <= 1'b0;
    end else begin
      cnt  <= cnt_next;
      tick <= (cnt_next == LO_CNT);
      if (cnt_next == LO_CNT) begin
        clk_out <= 1'b1;
      end else if (cnt_next == '0) begin
        clk_out <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_clock_divider.sv
// Self-checking bench for clock_divider: three instances (DIVIDER 10, 7, 2) against
// a cycle-count reference model via a scoreboard, plus edge-timing checks.
module tb_clock_divider;

  typedef struct {
    int   id;
    logic co;
    logic tk;
  } exp_t;

  logic clk = 1'b0;
  logic rst10 = 1'b0, rst7 = 1'b0, rst2 = 1'b0;
  logic out10, out7, out2;
  logic tick10, tick7, tick2;

  int checks = 0;
  int errors = 0;

  exp_t sb[$];
  int   k10 = 0, k7 = 0, k2 = 0;
  int   edgeCount = 0;
  int   tickCount7 = 0;

  time rise10[$], fall10[$], tickRise10[$], tickFall10[$];
  time rise7[$], fall7[$];
  time rise2[$], fall2[$], tickRise2[$];

  clock_divider #(.DIVIDER(10)) dut10 (.clk(clk), .reset(rst10), .clk_out(out10), .tick(tick10));
  clock_divider #(.DIVIDER(7))  dut7  (.clk(clk), .reset(rst7),  .clk_out(out7),  .tick(tick7));
  clock_divider #(.DIVIDER(2))  dut2  (.clk(clk), .reset(rst2),  .clk_out(out2),  .tick(tick2));

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0d, expected %0d at %0t", tag, actual, expected, $time);
    end
  endtask

  // Reference: after k edges out of reset the counter sits at k mod D.
  function automatic exp_t modelOf(input int id, input int k, input int d);
    exp_t e;
    int   lo;
    lo   = d - d / 2;
    e.id = id;
    e.co = ((k % d) >= lo);
    e.tk = ((k % d) == lo);
    return e;
  endfunction

  always @(posedge clk) begin
    edgeCount++;
    k10 = rst10 ? k10 + 1 : 0;
    k7  = rst7  ? k7  + 1 : 0;
    k2  = rst2  ? k2  + 1 : 0;
    sb.push_back(modelOf(10, k10, 10));
    sb.push_back(modelOf(7,  k7,  7));
    sb.push_back(modelOf(2,  k2,  2));
  end

  always @(posedge clk) begin
    exp_t e;
    #1;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      case (e.id)
        10: begin
          checkOutput("sb_d10_clk_out", 64'(out10), 64'(e.co));
          checkOutput("sb_d10_tick",    64'(tick10), 64'(e.tk));
        end
        7: begin
          checkOutput("sb_d7_clk_out", 64'(out7), 64'(e.co));
          checkOutput("sb_d7_tick",    64'(tick7), 64'(e.tk));
        end
        default: begin
          checkOutput("sb_d2_clk_out", 64'(out2), 64'(e.co));
          checkOutput("sb_d2_tick",    64'(tick2), 64'(e.tk));
        end
      endcase
    end
  end

  always @(posedge out10)  rise10.push_back($time);
  always @(negedge out10)  fall10.push_back($time);
  always @(posedge tick10) tickRise10.push_back($time);
  always @(negedge tick10) tickFall10.push_back($time);
  always @(posedge out7)   rise7.push_back($time);
  always @(negedge out7)   fall7.push_back($time);
  always @(posedge out2)   rise2.push_back($time);
  always @(negedge out2)   fall2.push_back($time);
  always @(posedge tick2)  tickRise2.push_back($time);
  always @(posedge tick7)  tickCount7++;

  task automatic applyStimulus();
    int  riseCount;
    int  edgesBefore;
    int  ticksBefore;
    int  risesBefore;
    int  waited;
    time releaseTime;

    #12;
    checkOutput("reset_clk_out", 64'(out10), 64'd0);
    checkOutput("reset_tick",    64'(tick10), 64'd0);
    #8;
    rst10 = 1'b1;
    rst7  = 1'b1;
    rst2  = 1'b1;
    repeat (102) @(posedge clk);
    #2;

    riseCount = 0;
    foreach (rise10[i]) if (rise10[i] > 20 && rise10[i] <= 1020) riseCount++;
    checkOutput("d10_rises_1us", 64'(riseCount), 64'd10);
    riseCount = 0;
    foreach (tickRise10[i]) if (tickRise10[i] > 20 && tickRise10[i] <= 1020) riseCount++;
    checkOutput("d10_ticks_1us", 64'(riseCount), 64'd10);
    if (rise10.size() >= 3 && fall10.size() >= 2 && tickRise10.size() >= 2 && tickFall10.size() >= 2) begin
      checkOutput("d10_first_rise",  64'(rise10[0]), 64'd65);
      checkOutput("d10_second_rise", 64'(rise10[1]), 64'd165);
      checkOutput("d10_third_rise",  64'(rise10[2]), 64'd265);
      checkOutput("d10_high_time",   64'(fall10[0] - rise10[0]), 64'd50);
      checkOutput("d10_tick_start",  64'(tickRise10[0]), 64'(rise10[0]));
      checkOutput("d10_tick_width",  64'(tickFall10[0] - tickRise10[0]), 64'd10);
      checkOutput("d10_tick2_width", 64'(tickFall10[1] - tickRise10[1]), 64'd10);
    end else begin
      checkOutput("d10_edges_seen", 64'(rise10.size()), 64'd3);
    end

    if (rise7.size() >= 6 && fall7.size() >= 5) begin
      checkOutput("d7_first_rise", 64'(rise7[0]), 64'd55);
      for (int i = 0; i < 5; i++) begin
        checkOutput($sformatf("d7_period_%0d", i), 64'(rise7[i+1] - rise7[i]), 64'd70);
        checkOutput($sformatf("d7_high_%0d", i),   64'(fall7[i] - rise7[i]),   64'd30);
      end
    end else begin
      checkOutput("d7_edges_seen", 64'(rise7.size()), 64'd6);
    end

    if (rise2.size() >= 4 && fall2.size() >= 3 && tickRise2.size() >= 3) begin
      checkOutput("d2_first_rise", 64'(rise2[0]), 64'd25);
      for (int i = 0; i < 3; i++) begin
        checkOutput($sformatf("d2_period_%0d", i), 64'(rise2[i+1] - rise2[i]), 64'd20);
        checkOutput($sformatf("d2_high_%0d", i),   64'(fall2[i] - rise2[i]),   64'd10);
      end
      checkOutput("d2_tick_spacing", 64'(tickRise2[1] - tickRise2[0]), 64'd20);
    end else begin
      checkOutput("d2_edges_seen", 64'(rise2.size()), 64'd4);
    end

    // Async reset in the middle of a high phase, between clock edges.
    waited = 0;
    do begin
      @(posedge clk);
      #1;
      waited++;
    end while (!(out10 === 1'b1 && tick10 === 1'b1) && waited < 30);
    checkOutput("d10_rise_found", 64'(out10), 64'd1);
    #2;
    edgesBefore = edgeCount;
    rst10 = 1'b0;
    #1;
    checkOutput("async_clk_out", 64'(out10), 64'd0);
    checkOutput("async_tick",    64'(tick10), 64'd0);
    checkOutput("async_no_edge", 64'(edgeCount), 64'(edgesBefore));
    repeat (3) @(negedge clk);
    #2;
    releaseTime = $time;
    risesBefore = rise10.size();
    rst10 = 1'b1;
    repeat (8) @(posedge clk);
    #2;
    if (rise10.size() > risesBefore) begin
      checkOutput("restart_rise", 64'(rise10[risesBefore] - releaseTime), 64'd43);
    end else begin
      checkOutput("restart_rise_seen", 64'(rise10.size()), 64'(risesBefore + 1));
    end

    // Long reset hold on the DIVIDER=7 instance.
    @(negedge clk);
    #2;
    rst7 = 1'b0;
    ticksBefore = tickCount7;
    repeat (100) @(posedge clk);
    #2;
    checkOutput("hold_tick_count", 64'(tickCount7), 64'(ticksBefore));
    checkOutput("hold_clk_out",    64'(out7), 64'd0);
    rst7 = 1'b1;
    repeat (10) @(posedge clk);
    #2;
  endtask

  initial begin
    applyStimulus();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/clock_divider.md
Name: clock_divider

Overview:
Parameterised integer clock divider. Derives a slow square wave `clk_out` from the system clock `clk`. It also provides a one-cycle strobe `tick` in the `clk` domain, aligned to each `clk_out` rising edge, for logic that should stay in the fast domain. It sits at the top of the design and feeds slow-rate consumers such as display refresh, debouncers and game timers.

Parameters:
- DIVIDER, 100_000_000, input clk cycles per clk_out period; integer >= 2 (elaboration error otherwise).
- CNT_W, $clog2(DIVIDER), derived counter width; localparam, not overridable.

Ports:
- clk  in  1  system clock; all state updates on its rising edge.
- reset  in  1  asynchronous, active-low reset (asserted when 0).
- clk_out  out  1  divided clock; period DIVIDER clk cycles.
- tick  out  1  one-clk-cycle pulse coincident with each clk_out rising edge.

Behaviour:
- Reset asserted (reset=0): immediately, without waiting for clk, cnt=0, clk_out=0, tick=0. Values hold while reset stays asserted.
- Counter cnt[CNT_W-1:0]: increments by 1 on each clk rising edge. Wraps DIVIDER-1 -> 0. It never reaches DIVIDER or above.
- Let HI = DIVIDER/2 (floor) and LO = DIVIDER - HI.
  - clk_out is a register, low for LO cycles and high for HI cycles.
  - On the edge where cnt becomes LO, clk_out becomes 1.
  - On the edge where cnt becomes 0 (wrap), clk_out becomes 0.
  - Even DIVIDER gives 50% duty. Odd DIVIDER gives low one cycle longer than high.
- tick: registered. It is 1 for exactly the clk cycle following the edge on which clk_out rises, and 0 otherwise.
- Latency: after reset release, the first clk_out rising edge occurs on the LO-th clk rising edge.
- clk_out is glitch-free because it is driven directly from a flop. It is meant for low-fanout or clock-enable use; tick is the preferred enable.
- Reset mid-operation: state is forced to its reset values asynchronously. The output then restarts with full timing from cnt=0, with no partial or short pulse.
- DIVIDER=2: clk_out toggles every clk edge, and tick is high every other cycle.
- No other inputs; the block is free-running whenever reset is deasserted.

Decomposition:
- Shared package holds no typedefs. A project-wide constant SYS_CLK_HZ (100_000_000) may live in the common constants package for computing DIVIDER at instantiation.
- A single module, with no sub-modules.
- The counter and the output decode stay in one file.

Test Plan:
1. DIVIDER=10, clk period 10 ns (edges at 5, 15, 25 ns…), reset=0 until 20 ns -> clk_out=0 and tick=0 during reset; first clk_out rise at 65 ns; subsequent rises every 100 ns (165, 265 …); clk_out high exactly 50 ns per period.
2. Same run: count clk_out rising edges in the 1000 ns after release -> 10 rises; tick high for exactly one 10 ns cycle starting at each rise.
3. Reset asserted mid-high-phase (clk_out=1) between clk edges -> clk_out and tick go 0 in the same timestep with no clk edge; after release, first rise again at the 5th clk edge.
4. DIVIDER=7 -> clk_out low 4 cycles, high 3 cycles, period 70 ns, repeatable across 5 periods.
5. DIVIDER=2 -> clk_out period 20 ns at 50% duty; tick high every second cycle.
6. Hold reset=0 for 100 clk cycles -> outputs stay 0 throughout, and no tick pulse is produced.
